// File: rtl/debug_hex_display.sv
// debug_hex_display: paged debug readout for the board's 7-segment HEX digits.
// One of NUM_SOURCES debug words is shown at a time. A debounced press of the
// board KEY steps to the next page. The freeze input holds the displayed value.
// Leading-zero blanking is optional.
// Optional feature macro HEX_DISPLAY_PAGE_INDICATOR_EN: when it is defined, the
// top digit shows the current page index instead of a data nibble.
module debug_hex_display #(
    parameter int NUM_DIGITS      = 8,
    parameter int NUM_SOURCES     = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SEL_BITS        = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] sources,
    input  logic                              next_key_n,
    input  logic                              freeze,
    input  logic                              blank_leading,
    output logic [NUM_DIGITS*7-1:0]           segments,
    output logic [SEL_BITS-1:0]               page_sel,
    output logic                              frozen
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
`ifdef HEX_DISPLAY_PAGE_INDICATOR_EN
    localparam int IND_DIGITS = 1;
`else
    localparam int IND_DIGITS = 0;
`endif
    // Number of digits that carry data nibbles; higher digits stay blank.
    localparam int DATA_DIGITS = ((NUM_DIGITS - IND_DIGITS) < (DATA_WIDTH / 4)) ?
                                 (NUM_DIGITS - IND_DIGITS) : (DATA_WIDTH / 4);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic                         key_meta;
    logic                         key_sync;
    logic                         key_db;
    logic                         key_db_q;
    logic [CNT_W-1:0]             db_cnt;
    logic                         press;
    logic                         page_chg_p1;
    logic                         vld_p1;
    logic [DATA_WIDTH-1:0]        src_sel;
    logic [DATA_WIDTH-1:0]        disp_reg_p1;
    logic [NUM_DIGITS*7-1:0]      seg_next;
    logic [NUM_DIGITS*7-1:0]      seg_p2;
    int                           top_nz;

    // Active-low 7-segment encoding, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // Two-flop synchronizer for the raw, asynchronous KEY; idles as "released".
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= next_key_n;
            key_sync <= key_meta;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_db   <= 1'b1;
            key_db_q <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_db_q <= key_db;
            if (key_sync != key_db) begin
                if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_db <= key_sync;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // A press is the debounced 1->0 edge. A release does not generate an event.
    assign press = key_db_q & ~key_db;

    // Page index steps on each press and wraps after the last source.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            page_sel    <= '0;
            page_chg_p1 <= 1'b0;
            frozen      <= 1'b0;
        end else begin
            page_chg_p1 <= press;
            frozen      <= freeze;
            if (press) begin
                if (page_sel == SEL_BITS'(NUM_SOURCES - 1)) page_sel <= '0;
                else                                        page_sel <= page_sel + 1'b1;
            end
        end
    end

    // Select the debug word addressed by the current page.
    always_comb begin
        src_sel = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (int'(page_sel) == k) src_sel = sources[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Stage p1: capture the word. A page change forces one load even while frozen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_reg_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= 1'b1;
            if (!freeze || page_chg_p1) disp_reg_p1 <= src_sel;
        end
    end

    // Encode the digits, with optional blanking above the most significant nonzero nibble.
    always_comb begin
        top_nz   = 0;
        seg_next = {NUM_DIGITS{SEG_BLANK}};
        for (int d = 0; d < DATA_DIGITS; d++) begin
            if (disp_reg_p1[d*4 +: 4] != 4'h0) top_nz = d;
        end
        for (int d = 0; d < DATA_DIGITS; d++) begin
            if (!(blank_leading && (d > top_nz))) seg_next[d*7 +: 7] = hex7(disp_reg_p1[d*4 +: 4]);
        end
`ifdef HEX_DISPLAY_PAGE_INDICATOR_EN
        seg_next[(NUM_DIGITS-1)*7 +: 7] = hex7(4'(page_sel));
`endif
    end

    // Stage p2: register the segments. They stay blank until the first word has been captured.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) seg_p2 <= {NUM_DIGITS{SEG_BLANK}};
        else        seg_p2 <= vld_p1 ? seg_next : {NUM_DIGITS{SEG_BLANK}};
    end

    assign segments = seg_p2;

endmodule

// File: tb/tb_debug_hex_display.sv
// Self-checking bench for debug_hex_display with DEBOUNCE_CYCLES=4, NUM_SOURCES=3, NUM_DIGITS=8.
module tb_debug_hex_display;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [95:0] sources;
    logic        next_key_n = 1'b1;
    logic        freeze = 1'b0;
    logic        blank_leading = 1'b0;
    logic [55:0] segments;
    logic [1:0]  page_sel;
    logic        frozen;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [55:0] seg_q[$];
    int          page_q[$];
    logic [55:0] exp_seg;
    int          exp_page;

    debug_hex_display #(
        .NUM_DIGITS(8), .NUM_SOURCES(3), .DATA_WIDTH(32), .DEBOUNCE_CYCLES(4), .SEL_BITS(2)
    ) dut (
        .clock(clock), .reset(reset), .sources(sources), .next_key_n(next_key_n),
        .freeze(freeze), .blank_leading(blank_leading), .segments(segments),
        .page_sel(page_sel), .frozen(frozen)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] ref_hex(input logic [3:0] n);
        logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[n];
    endfunction

    // Expected segment image for a displayed word, blanking mode and page.
    function automatic logic [55:0] model_segs(input logic [31:0] v, input logic bl, input int pg);
        logic [55:0] s;
        int ndata;
        int top;
`ifdef HEX_DISPLAY_PAGE_INDICATOR_EN
        ndata = 7;
`else
        ndata = 8;
`endif
        top = 0;
        s = {8{7'h7F}};
        for (int i = 0; i < ndata; i++) if (v[i*4 +: 4] != 4'h0) top = i;
        for (int d = 0; d < ndata; d++) if (!(bl && d > top)) s[d*7 +: 7] = ref_hex(v[d*4 +: 4]);
`ifdef HEX_DISPLAY_PAGE_INDICATOR_EN
        s[49 +: 7] = ref_hex(4'(pg));
`endif
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic key_press(input int low_cycles);
        next_key_n = 1'b0;
        tick(low_cycles);
        next_key_n = 1'b1;
        tick(10);
    endtask

    task automatic test_reset;
        sources = {32'h0000_0000, 32'hCAFE_0001, 32'h1234_5678};
        reset = 1'b0;
        tick(3);
        n_cmp++;
        if (segments !== {8{7'h7F}}) begin n_fail++; $display("FAIL reset_segments: got %h want %h", segments, {8{7'h7F}}); end
        n_cmp++;
        if (page_sel !== 2'd0) begin n_fail++; $display("FAIL reset_page: got %0d want 0", page_sel); end
        n_cmp++;
        if (frozen !== 1'b0) begin n_fail++; $display("FAIL reset_frozen: got %b want 0", frozen); end
        reset = 1'b1;
        seg_q.push_back({8{7'h7F}});
        seg_q.push_back(model_segs(32'h1234_5678, 1'b0, 0));
        tick(1);
        exp_seg = seg_q.pop_front();
        n_cmp++;
        if (segments !== exp_seg) begin n_fail++; $display("FAIL release_1clk: got %h want %h", segments, exp_seg); end
        tick(1);
        exp_seg = seg_q.pop_front();
        n_cmp++;
        if (segments !== exp_seg) begin n_fail++; $display("FAIL release_2clk: got %h want %h", segments, exp_seg); end
    endtask

    task automatic test_short_press;
        page_q.push_back(0);
        key_press(3);
        exp_page = page_q.pop_front();
        n_cmp++;
        if (page_sel !== 2'(exp_page)) begin n_fail++; $display("FAIL short_press: got %0d want %0d", page_sel, exp_page); end
    endtask

    task automatic test_wrap;
        logic [31:0] words [3];
        words[0] = sources[31:0];
        words[1] = sources[63:32];
        words[2] = sources[95:64];
        for (int i = 0; i < 3; i++) begin
            page_q.push_back((i + 1) % 3);
            seg_q.push_back(model_segs(words[(i + 1) % 3], 1'b0, (i + 1) % 3));
            key_press(8);
            exp_page = page_q.pop_front();
            exp_seg  = seg_q.pop_front();
            n_cmp++;
            if (page_sel !== 2'(exp_page)) begin n_fail++; $display("FAIL wrap_page%0d: got %0d want %0d", i, page_sel, exp_page); end
            n_cmp++;
            if (segments !== exp_seg) begin n_fail++; $display("FAIL wrap_segs%0d: got %h want %h", i, segments, exp_seg); end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] pat;
        pat = 4'b1010;
        page_q.push_back(1);
        for (int i = 0; i < 4; i++) begin
            next_key_n = pat[i];
            tick(1);
        end
        key_press(8);
        exp_page = page_q.pop_front();
        n_cmp++;
        if (page_sel !== 2'(exp_page)) begin n_fail++; $display("FAIL bounce_page: got %0d want %0d", page_sel, exp_page); end
    endtask

    task automatic test_freeze;
        freeze = 1'b1;
        tick(1);
        sources[63:32] = 32'h0;
        seg_q.push_back(model_segs(32'hCAFE_0001, 1'b0, 1));
        tick(4);
        exp_seg = seg_q.pop_front();
        n_cmp++;
        if (segments !== exp_seg) begin n_fail++; $display("FAIL freeze_hold: got %h want %h", segments, exp_seg); end
        n_cmp++;
        if (frozen !== 1'b1) begin n_fail++; $display("FAIL frozen_flag: got %b want 1", frozen); end
        sources[95:64] = 32'h0000_00A5;
        tick(3);
        seg_q.push_back(model_segs(32'h0000_00A5, 1'b0, 2));
        page_q.push_back(2);
        key_press(8);
        exp_seg  = seg_q.pop_front();
        exp_page = page_q.pop_front();
        n_cmp++;
        if (page_sel !== 2'(exp_page)) begin n_fail++; $display("FAIL frozen_page: got %0d want %0d", page_sel, exp_page); end
        n_cmp++;
        if (segments !== exp_seg) begin n_fail++; $display("FAIL frozen_pageload: got %h want %h", segments, exp_seg); end
        sources[95:64] = 32'hFFFF_FFFF;
        seg_q.push_back(model_segs(32'h0000_00A5, 1'b0, 2));
        tick(4);
        exp_seg = seg_q.pop_front();
        n_cmp++;
        if (segments !== exp_seg) begin n_fail++; $display("FAIL frozen_after_load: got %h want %h", segments, exp_seg); end
        freeze = 1'b0;
        seg_q.push_back(model_segs(32'hFFFF_FFFF, 1'b0, 2));
        tick(2);
        exp_seg = seg_q.pop_front();
        n_cmp++;
        if (segments !== exp_seg) begin n_fail++; $display("FAIL unfreeze: got %h want %h", segments, exp_seg); end
        n_cmp++;
        if (frozen !== 1'b0) begin n_fail++; $display("FAIL unfrozen_flag: got %b want 0", frozen); end
    endtask

    task automatic test_blank;
        blank_leading = 1'b1;
        sources[95:64] = 32'h0000_00A5;
        seg_q.push_back(model_segs(32'h0000_00A5, 1'b1, 2));
        tick(2);
        exp_seg = seg_q.pop_front();
        n_cmp++;
        if (segments !== exp_seg) begin n_fail++; $display("FAIL blank_a5: got %h want %h", segments, exp_seg); end
        n_cmp++;
        if (segments[13:0] !== {7'h08, 7'h12}) begin n_fail++; $display("FAIL blank_a5_low: got %h want %h", segments[13:0], {7'h08, 7'h12}); end
        sources[95:64] = 32'h0;
        seg_q.push_back(model_segs(32'h0, 1'b1, 2));
        tick(2);
        exp_seg = seg_q.pop_front();
        n_cmp++;
        if (segments !== exp_seg) begin n_fail++; $display("FAIL blank_zero: got %h want %h", segments, exp_seg); end
        n_cmp++;
        if (segments[6:0] !== 7'h40) begin n_fail++; $display("FAIL blank_zero_d0: got %h want 40", segments[6:0]); end
        blank_leading = 1'b0;
    endtask

    task automatic test_indicator;
        logic [6:0] exp_d7;
`ifdef HEX_DISPLAY_PAGE_INDICATOR_EN
        exp_d7 = 7'h24;
`else
        exp_d7 = 7'h30;
`endif
        sources[95:64] = 32'h3000_0000;
        seg_q.push_back(model_segs(32'h3000_0000, 1'b0, 2));
        tick(2);
        exp_seg = seg_q.pop_front();
        n_cmp++;
        if (segments[55:49] !== exp_d7) begin n_fail++; $display("FAIL digit7: got %h want %h", segments[55:49], exp_d7); end
        n_cmp++;
        if (segments !== exp_seg) begin n_fail++; $display("FAIL indicator_segs: got %h want %h", segments, exp_seg); end
    endtask

    task automatic test_reset_mid_debounce;
        freeze = 1'b1;
        next_key_n = 1'b0;
        tick(3);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (page_sel !== 2'd0) begin n_fail++; $display("FAIL midreset_page: got %0d want 0", page_sel); end
        n_cmp++;
        if (segments !== {8{7'h7F}}) begin n_fail++; $display("FAIL midreset_segs: got %h want %h", segments, {8{7'h7F}}); end
        n_cmp++;
        if (frozen !== 1'b0) begin n_fail++; $display("FAIL midreset_frozen: got %b want 0", frozen); end
        freeze = 1'b0;
        tick(2);
        reset = 1'b1;
        page_q.push_back(0);
        page_q.push_back(1);
        tick(6);
        exp_page = page_q.pop_front();
        n_cmp++;
        if (page_sel !== 2'(exp_page)) begin n_fail++; $display("FAIL postreset_early: got %0d want %0d", page_sel, exp_page); end
        tick(1);
        exp_page = page_q.pop_front();
        n_cmp++;
        if (page_sel !== 2'(exp_page)) begin n_fail++; $display("FAIL postreset_page: got %0d want %0d", page_sel, exp_page); end
        next_key_n = 1'b1;
        tick(10);
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_wrap();
        test_bounce();
        test_freeze();
        test_blank();
        test_indicator();
        test_reset_mid_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
